// File: rtl/cavenger_pkg.sv
// ============================================================================
// Module      : cavenger_pkg
// Description : Shared types and constants for the Cosmic Avenger ROM loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cavenger_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } seq_state_t;

    localparam int REGION_BITS = 2;

    localparam logic [REGION_BITS-1:0] CPU0 = 2'd0;
    localparam logic [REGION_BITS-1:0] CPU1 = 2'd1;
    localparam logic [REGION_BITS-1:0] GFX  = 2'd2;
    localparam logic [REGION_BITS-1:0] PROM = 2'd3;

    // One-hot region select from the top address bits of a write.
    function automatic logic [(1<<REGION_BITS)-1:0] region_onehot(
        input logic [REGION_BITS-1:0] idx
    );
        logic [(1<<REGION_BITS)-1:0] v;
        v = '0;
        case (idx)
            CPU0:    v = 4'b0001;
            CPU1:    v = 4'b0010;
            GFX:     v = 4'b0100;
            PROM:    v = 4'b1000;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_stretch.sv
// ============================================================================
// Module      : reset_stretch
// Description : Loadable down-counter timing the core reset hold period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_stretch #(
    parameter int RESET_HOLD = 1024
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic reload,
    input  logic dec,
    output logic zero
);

    localparam int                 c_cnt_w    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(RESET_HOLD - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= c_load_val;
        end else if (reload) begin
            r_count <= c_load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/rom_load_sequencer.sv
// ============================================================================
// Module      : rom_load_sequencer
// Description : Qualifies the hps_io download stream into dn_* writes and
//               sequences the core reset around power-up, loads and requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_load_sequencer
    import cavenger_pkg::*;
#(
    parameter int EXPECTED_BYTES = 49152,
    parameter int RESET_HOLD     = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        reset_req,
    output logic        core_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [3:0]  dn_region,
    output logic        load_done,
    output logic        size_err,
    output logic [15:0] rom_sum
);

    localparam logic [16:0] c_expected = 17'(EXPECTED_BYTES);

    seq_state_t  r_state;
    seq_state_t  w_next_state;
    logic        w_reload;
    logic        w_dec;
    logic        w_cnt_zero;

    logic        r_core_reset;
    logic [15:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    logic        r_dn_wr;
    logic [3:0]  r_dn_region;
    logic        r_load_done;
    logic        r_size_err;
    logic [15:0] r_rom_sum;
    logic [16:0] r_byte_count;
    logic        r_overflow;

    logic        w_accept;
    logic        w_drop;
    logic        w_entering;
    logic        w_closing;
    logic [16:0] w_count_base;
    logic [15:0] w_sum_base;
    logic        w_ovf_base;

    reset_stretch #(
        .RESET_HOLD (RESET_HOLD)
    ) u_reset_stretch (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .reload  (w_reload),
        .dec     (w_dec),
        .zero    (w_cnt_zero)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_reload     = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            HOLD: begin
                if (ioctl_download) begin
                    w_next_state = LOAD;
                end else if (reset_req) begin
                    w_reload = 1'b1;
                end else if (w_cnt_zero) begin
                    w_next_state = RUN;
                end else begin
                    w_dec = 1'b1;
                end
            end
            RUN: begin
                if (ioctl_download) begin
                    w_next_state = LOAD;
                end else if (reset_req) begin
                    w_next_state = HOLD;
                    w_reload     = 1'b1;
                end
            end
            LOAD: begin
                if (!ioctl_download) begin
                    w_next_state = HOLD;
                    w_reload     = 1'b1;
                end
            end
            default: begin
                w_next_state = HOLD;
                w_reload     = 1'b1;
            end
        endcase
    end

    // Window accounting restarts on entry, so a byte in the first cycle lands on a cleared base.
    always_comb begin
        w_accept     = ioctl_wr && ioctl_download && (ioctl_addr[24:16] == '0);
        w_drop       = ioctl_wr && ioctl_download && (ioctl_addr[24:16] != '0);
        w_entering   = (r_state != LOAD) && ioctl_download;
        w_closing    = (r_state == LOAD) && !ioctl_download;
        w_count_base = w_entering ? '0 : r_byte_count;
        w_sum_base   = w_entering ? '0 : r_rom_sum;
        w_ovf_base   = w_entering ? 1'b0 : r_overflow;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_core_reset <= 1'b1;
            r_dn_wr      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_dn_region  <= '0;
            r_load_done  <= 1'b0;
            r_size_err   <= 1'b0;
            r_rom_sum    <= '0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_core_reset <= (w_next_state != RUN);
            r_dn_wr      <= w_accept;
            if (w_accept) begin
                r_dn_addr    <= ioctl_addr[15:0];
                r_dn_data    <= ioctl_dout;
                r_dn_region  <= region_onehot(ioctl_addr[15:14]);
                r_byte_count <= (w_count_base == '1) ? w_count_base : w_count_base + 17'd1;
                r_rom_sum    <= w_sum_base + {8'h00, ioctl_dout};
            end else begin
                r_byte_count <= w_count_base;
                r_rom_sum    <= w_sum_base;
            end
            r_overflow <= w_ovf_base | w_drop;
            if (w_entering) begin
                r_load_done <= 1'b0;
                r_size_err  <= 1'b0;
            end else if (w_closing) begin
                r_load_done <= 1'b1;
                r_size_err  <= r_overflow || (r_byte_count != c_expected);
            end
        end
    end

    assign core_reset = r_core_reset;
    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign dn_wr      = r_dn_wr;
    assign dn_region  = r_dn_region;
    assign load_done  = r_load_done;
    assign size_err   = r_size_err;
    assign rom_sum    = r_rom_sum;

endmodule

`default_nettype wire

// File: tb/tb_rom_load_sequencer.sv
// ============================================================================
// Module      : tb_rom_load_sequencer
// Description : Directed self-checking bench for rom_load_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_load_sequencer;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        reset_req;
    logic        core_reset;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [3:0]  dn_region;
    logic        load_done;
    logic        size_err;
    logic [15:0] rom_sum;

    int n_pass;
    int n_total;

    rom_load_sequencer #(
        .EXPECTED_BYTES (3),
        .RESET_HOLD     (1024)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .reset_req      (reset_req),
        .core_reset     (core_reset),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .dn_region      (dn_region),
        .load_done      (load_done),
        .size_err       (size_err),
        .rom_sum        (rom_sum)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input string tag, input logic [24:0] a, input logic [7:0] d,
                             input logic [3:0] region);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        check({tag, "_wr"},     32'(dn_wr),     32'h1);
        check({tag, "_addr"},   32'(dn_addr),   32'(a[15:0]));
        check({tag, "_data"},   32'(dn_data),   32'(d));
        check({tag, "_region"}, 32'(dn_region), 32'(region));
        ioctl_wr = 1'b0;
    endtask

    // Counts edges until core_reset falls; the call point is the hold-entry edge.
    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while ((core_reset === 1'b1) && (n < 2000)) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd1024);
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        reset_req      = 1'b0;

        repeat (3) tick();
        check("rst_core_reset", 32'(core_reset), 32'h1);
        check("rst_dn_wr",      32'(dn_wr),      32'h0);
        check("rst_dn_addr",    32'(dn_addr),    32'h0);
        check("rst_dn_region",  32'(dn_region),  32'h0);
        check("rst_load_done",  32'(load_done),  32'h0);
        check("rst_size_err",   32'(size_err),   32'h0);
        check("rst_rom_sum",    32'(rom_sum),    32'h0);

        reset_n = 1'b1;
        wait_release("powerup_hold");
        check("powerup_load_done", 32'(load_done), 32'h0);

        // Full 3-byte load; a strobe after download drops must be ignored.
        ioctl_download = 1'b1;
        send_byte("b0", 25'h0000000, 8'h12, 4'b0001);
        check("load_core_reset", 32'(core_reset), 32'h1);
        send_byte("b1", 25'h0004001, 8'h34, 4'b0010);
        send_byte("b2", 25'h000C002, 8'hFF, 4'b1000);
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'h0000005;
        ioctl_dout     = 8'h55;
        tick();
        ioctl_wr = 1'b0;
        check("close_dn_wr",     32'(dn_wr),     32'h0);
        check("close_dn_addr",   32'(dn_addr),   32'h0000C002);
        check("close_load_done", 32'(load_done), 32'h1);
        check("close_size_err",  32'(size_err),  32'h0);
        check("close_rom_sum",   32'(rom_sum),   32'h0145);
        wait_release("load_hold");

        // Short load: 2 of 3 bytes.
        ioctl_download = 1'b1;
        send_byte("s0", 25'h0000000, 8'h01, 4'b0001);
        check("short_entry_load_done", 32'(load_done), 32'h0);
        check("short_entry_sum",       32'(rom_sum),   32'h0001);
        send_byte("s1", 25'h0000001, 8'h02, 4'b0001);
        ioctl_download = 1'b0;
        tick();
        check("short_load_done", 32'(load_done), 32'h1);
        check("short_size_err",  32'(size_err),  32'h1);
        check("short_rom_sum",   32'(rom_sum),   32'h0003);
        wait_release("short_hold");

        // Correct count but one out-of-range strobe.
        ioctl_download = 1'b1;
        send_byte("o0", 25'h0000000, 8'h10, 4'b0001);
        send_byte("o1", 25'h0004000, 8'h20, 4'b0010);
        send_byte("o2", 25'h0008000, 8'h30, 4'b0100);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h0010000;
        ioctl_dout = 8'hAA;
        tick();
        ioctl_wr = 1'b0;
        check("ovf_no_dn_wr", 32'(dn_wr), 32'h0);
        ioctl_download = 1'b0;
        tick();
        check("ovf_load_done", 32'(load_done), 32'h1);
        check("ovf_size_err",  32'(size_err),  32'h1);
        check("ovf_rom_sum",   32'(rom_sum),   32'h0060);
        wait_release("ovf_hold");

        // reset_req pulse in RUN.
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        check("req_pulse_core_reset", 32'(core_reset), 32'h1);
        wait_release("req_pulse_hold");

        // reset_req held 500 cycles.
        reset_req = 1'b1;
        tick();
        check("req_held_rise", 32'(core_reset), 32'h1);
        repeat (499) tick();
        check("req_held_still", 32'(core_reset), 32'h1);
        reset_req = 1'b0;
        wait_release("req_held_hold");

        // reset_req during LOAD has no effect on the window.
        ioctl_download = 1'b1;
        reset_req      = 1'b1;
        send_byte("r0", 25'h0000100, 8'h01, 4'b0001);
        send_byte("r1", 25'h0004100, 8'h02, 4'b0010);
        send_byte("r2", 25'h0008100, 8'h03, 4'b0100);
        ioctl_download = 1'b0;
        reset_req      = 1'b0;
        tick();
        check("reqload_load_done", 32'(load_done), 32'h1);
        check("reqload_size_err",  32'(size_err),  32'h0);
        check("reqload_rom_sum",   32'(rom_sum),   32'h0006);
        wait_release("reqload_hold");

        // Asynchronous reset mid-load drops the pending write.
        ioctl_download = 1'b1;
        send_byte("a0", 25'h0000200, 8'h77, 4'b0001);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h0000201;
        ioctl_dout = 8'h88;
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_core_reset", 32'(core_reset), 32'h1);
        check("abort_dn_wr",      32'(dn_wr),      32'h0);
        check("abort_dn_addr",    32'(dn_addr),    32'h0);
        check("abort_dn_data",    32'(dn_data),    32'h0);
        check("abort_dn_region",  32'(dn_region),  32'h0);
        check("abort_rom_sum",    32'(rom_sum),    32'h0);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        check("abort_held_dn_wr", 32'(dn_wr), 32'h0);
        reset_n = 1'b1;
        wait_release("abort_hold");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
